// File: rtl/shift_add_arbiter.sv
// Two-requester round-robin arbiter sharing one add / serial-shift datapath.
// Ports: req_{valid,ready,op,a,b}_{0,1} command channels; rsp_* result strobe; busy.
module shift_add_arbiter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [1:0]       req_op_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [1:0]       req_op_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SHL  = 2'd1;
  localparam logic [1:0] OP_SHR  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             busy_q, busy_d;

  logic             idle;
  logic             gnt_1;
  logic             accept;
  logic [WIDTH:0]   sum;
  logic             finish;
  logic             carry_n;
  logic [WIDTH-1:0] sel_b;

  // On a tie the port that did not win last time gets the grant.
  assign idle   = (state_q == IDLE);
  assign gnt_1  = (req_valid_0 && req_valid_1) ? !last_grant_q
                                               : req_valid_1;
  assign req_ready_0 = idle && req_valid_0 && !gnt_1;
  assign req_ready_1 = idle && req_valid_1 && gnt_1;
  assign accept = req_ready_0 || req_ready_1;

  assign sum   = {1'b0, acc_q} + {1'b0, b_q};
  assign sel_b = gnt_1 ? req_b_1 : req_b_0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    b_d          = b_q;
    id_d         = id_q;
    acc_d        = acc_q;
    count_d      = count_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    finish       = 1'b0;
    carry_n      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = gnt_1 ? req_op_1 : req_op_0;
          acc_d        = gnt_1 ? req_a_1 : req_a_0;
          b_d          = sel_b;
          count_d      = sel_b[SHW-1:0];
          id_d         = gnt_1;
          last_grant_d = gnt_1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            acc_d   = sum[WIDTH-1:0];
            carry_n = sum[WIDTH];
            finish  = 1'b1;
          end
          OP_SHL: begin
            if (count_q != '0) begin
              acc_d   = {acc_q[WIDTH-2:0], 1'b0};
              count_d = count_q - SHW'(1);
            end else begin
              finish = 1'b1;
            end
          end
          OP_SHR: begin
            if (count_q != '0) begin
              acc_d   = {1'b0, acc_q[WIDTH-1:1]};
              count_d = count_q - SHW'(1);
            end else begin
              finish = 1'b1;
            end
          end
          OP_PASS: finish = 1'b1;
          default: finish = 1'b1;
        endcase
        // The response registers load on the edge entering DONE so the
        // strobe lines up with the DONE cycle.
        if (finish) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = acc_d;
          rsp_id_d    = id_q;
          rsp_carry_d = carry_n;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      acc_q        <= '0;
      count_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      b_q          <= b_d;
      id_q         <= id_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = busy_q;

endmodule
